// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC mode encodings
// and the mode field width.
package pc_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        PC_INC  = 3'd0,
        PC_BR   = 3'd1,
        PC_JMP  = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_mode_e;

    // Encodings 5..7 are reserved and behave as a plain increment.
    function automatic pc_mode_e decode_mode(input logic [MODE_W-1:0] raw);
        case (raw)
            3'd1:    return PC_BR;
            3'd2:    return PC_JMP;
            3'd3:    return PC_CALL;
            3'd4:    return PC_RET;
            default: return PC_INC;
        endcase
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle of the program-counter unit. The master side issues
// next-PC requests; the slave side (pc_unit) returns the PC and stack status.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);

    logic                       pc_ld;
    logic [pc_pkg::MODE_W-1:0]  pc_mode;
    logic [WIDTH-1:0]           pc_in;
    logic [WIDTH-1:0]           pc_off;
    logic [WIDTH-1:0]           pc_out;
    logic                       ras_empty;
    logic                       ras_full;
    logic                       ras_err;

    modport master (
        output pc_ld, pc_mode, pc_in, pc_off,
        input  pc_out, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  pc_ld, pc_mode, pc_in, pc_off,
        output pc_out, ras_empty, ras_full, ras_err
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry; a pop while empty is ignored. DEPTH must be a power of two.
module pc_ras #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;

    // wr_ptr always points one past the newest entry; since DEPTH is a power
    // of two the pointer wraps naturally, and the slot it overwrites when
    // full is exactly the oldest entry.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (cnt != CNT_W'(DEPTH)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (pop && (cnt != '0)) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            cnt    <= cnt - CNT_W'(1);
        end
    end

    // NOTE: storage is deliberately left out of reset; the count alone
    // decides which entries are valid, and an unreset array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign top   = mem[wr_ptr - PTR_W'(1)];
    assign count = cnt;
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: increment, branch, jump, and (with PC_RAS_EN defined)
// call/return through a return-address stack. Without PC_RAS_EN, CALL acts as JMP and RET as INC.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_unit_if.slave  bus
);

    pc_mode_e         mode;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] pc_seq;

    assign mode       = decode_mode(bus.pc_mode);
    assign pc_seq     = pc_q + WIDTH'(STEP);
    assign bus.pc_out = pc_q;

`ifdef PC_RAS_EN
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH+1);

    logic             push_req;
    logic             pop_req;
    logic             err_d;
    logic             err_q;
    logic [WIDTH-1:0] ras_top;
    logic [CNT_W-1:0] ras_count;
    logic             ras_full;
    logic             ras_empty;

    // Stack updates only on a loaded cycle; reset inside pc_ras wins over both.
    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.pc_ld && push_req),
        .pop       (bus.pc_ld && pop_req),
        .push_data (pc_seq),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );
`endif

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        pc_nxt   = pc_seq;
`ifdef PC_RAS_EN
        push_req = 1'b0;
        pop_req  = 1'b0;
        err_d    = 1'b0;
`endif
        unique case (mode)
            PC_BR:   pc_nxt = pc_q + bus.pc_off;
            PC_JMP:  pc_nxt = bus.pc_in;
            PC_CALL: begin
                pc_nxt   = bus.pc_in;
`ifdef PC_RAS_EN
                push_req = 1'b1;
                err_d    = (ras_count == CNT_W'(RAS_DEPTH));
`endif
            end
            PC_RET: begin
`ifdef PC_RAS_EN
                if (ras_count != '0) begin
                    pc_nxt  = ras_top;
                    pop_req = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
`else
                pc_nxt = pc_seq;
`endif
            end
            default: pc_nxt = pc_seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else if (bus.pc_ld) begin
            pc_q <= pc_nxt;
        end
    end

`ifdef PC_RAS_EN
    // The error is a single-cycle pulse; a stalled cycle always clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bus.pc_ld && err_d;
        end
    end

    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_err   = err_q;
`else
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
    assign bus.ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (WIDTH=8, RAS_DEPTH=4): directed scenarios
// then random traffic, all compared against a queue-based reference model.
module tb_pc_unit;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MASK  = (1 << W) - 1;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    pc_unit_if #(.WIDTH(W)) bus ();

    pc_unit #(
        .WIDTH     (W),
        .STEP      (1),
        .RESET_VEC ('0),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: PC value, stack as a queue (back = newest), error flag.
    int unsigned m_pc = 0;
    int unsigned m_stack[$];
    bit          m_err = 1'b0;

    function automatic void model_step(input bit r, input bit ld, input int unsigned mode,
                                       input int unsigned in, input int unsigned off);
        if (r) begin
            m_pc = 0;
            m_stack.delete();
            m_err = 1'b0;
        end else if (!ld) begin
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            case (mode)
                1: m_pc = (m_pc + off) & MASK;
                2: m_pc = in & MASK;
                3: begin
                    if (RAS_ON) begin
                        if (m_stack.size() == DEPTH) begin
                            void'(m_stack.pop_front());
                            m_err = 1'b1;
                        end
                        m_stack.push_back((m_pc + 1) & MASK);
                    end
                    m_pc = in & MASK;
                end
                4: begin
                    if (RAS_ON && m_stack.size() > 0) begin
                        m_pc = m_stack.pop_back();
                    end else begin
                        m_pc = (m_pc + 1) & MASK;
                        m_err = RAS_ON;
                    end
                end
                default: m_pc = (m_pc + 1) & MASK;
            endcase
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input bit r, input bit ld, input int unsigned mode,
                         input int unsigned in, input int unsigned off, input string tag);
        rst         = r;
        bus.pc_ld   = ld;
        bus.pc_mode = 3'(mode);
        bus.pc_in   = W'(in);
        bus.pc_off  = W'(off);
        model_step(r, ld, mode, in, off);
        @(posedge clk);
        #1;
        check({tag, ".pc"},    32'(bus.pc_out),    32'(m_pc));
        check({tag, ".empty"}, 32'(bus.ras_empty), 32'(m_stack.size() == 0));
        check({tag, ".full"},  32'(bus.ras_full),  32'(m_stack.size() == DEPTH));
        check({tag, ".err"},   32'(bus.ras_err),   32'(m_err));
    endtask

    initial begin
        rst         = 1'b1;
        bus.pc_ld   = 1'b0;
        bus.pc_mode = '0;
        bus.pc_in   = '0;
        bus.pc_off  = '0;

        // Reset then three increments.
        apply(1, 0, 0, 0, 0, "reset");
        check("reset_pc_lit", 32'(bus.pc_out), 32'd0);
        for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 0, "inc");
        check("inc3_lit", 32'(bus.pc_out), 32'd3);

        // Stall, negative branch, jump.
        apply(0, 1, 2, 10, 0, "jmp10");
        apply(0, 0, 3, 77, 0, "stall1");
        apply(0, 0, 4, 0, 0, "stall2");
        check("stall_lit", 32'(bus.pc_out), 32'd10);
        apply(0, 1, 1, 0, 32'hFFFF_FFFC, "br_m4");
        check("br_lit", 32'(bus.pc_out), 32'd6);
        apply(0, 1, 2, 100, 0, "jmp100");
        check("jmp_lit", 32'(bus.pc_out), 32'd100);

        // Call / return.
        apply(0, 1, 2, 5, 0, "jmp5");
        apply(0, 1, 3, 40, 0, "call40");
        apply(0, 1, 0, 0, 0, "inc41");
        apply(0, 1, 4, 0, 0, "ret");

        // Overflow and underflow of the stack.
        apply(1, 1, 0, 0, 0, "reset2");
        for (int i = 0; i < 5; i++) apply(0, 1, 3, 16 * (i + 1), 0, "call_fill");
        for (int i = 0; i < 4; i++) apply(0, 1, 4, 0, 0, "ret_drain");
        apply(0, 1, 4, 0, 0, "ret_under");
        apply(0, 1, 0, 0, 0, "err_clear");

        // Wrap-around and reset priority over a call.
        apply(0, 1, 2, 255, 0, "jmp255");
        apply(0, 1, 0, 0, 0, "wrap");
        check("wrap_lit", 32'(bus.pc_out), 32'd0);
        apply(0, 1, 3, 50, 0, "call_pre");
        apply(1, 1, 3, 60, 0, "rst_call");
        check("rst_call_lit", 32'(bus.pc_out), 32'd0);

        // Random traffic; modes weighted toward call/return to exercise the stack.
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          ld;
            int unsigned mode;
            r    = ($urandom_range(0, 99) == 0);
            ld   = ($urandom_range(0, 4) != 0);
            mode = ($urandom_range(0, 1) == 0) ? $urandom_range(3, 4) : $urandom_range(0, 7);
            apply(r, ld, mode, $urandom_range(0, MASK), $urandom_range(0, MASK), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32, PC and address width in bits.
REQ-002 Parameter STEP, default 1, sequential increment added to PC.
REQ-003 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 pc_ld  input  1  update enable; 0 = hold all state (stall).
REQ-008 pc_mode  input  3  next-PC select: 0 INC, 1 BR, 2 JMP, 3 CALL, 4 RET, 5-7 treated as INC.
REQ-009 pc_in  input  WIDTH  absolute target for JMP/CALL.
REQ-010 pc_off  input  WIDTH  two's-complement offset for BR.
REQ-011 pc_out  output  WIDTH  current PC, registered.
REQ-012 ras_empty  output  1  stack holds zero valid entries.
REQ-013 ras_full  output  1  stack holds RAS_DEPTH valid entries.
REQ-014 ras_err  output  1  one-cycle pulse on RET-with-empty or CALL-with-full.

Function
REQ-015 pc_ld=0: pc_out, stack contents, count unchanged; ras_err=0 next cycle.
REQ-016 pc_ld=1, INC: pc_out <= pc_out+STEP, one-cycle latency.
REQ-017 pc_ld=1, BR: pc_out <= pc_out+pc_off.
REQ-018 pc_ld=1, JMP: pc_out <= pc_in.
REQ-019 pc_ld=1, CALL: push pc_out+STEP onto stack, pc_out <= pc_in, same edge.
REQ-020 pc_ld=1, RET, stack non-empty: pc_out <= top entry, pop.
REQ-021 RET with stack empty: pc_out <= pc_out+STEP, count stays 0, ras_err=1 for one cycle.
REQ-022 CALL with stack full: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_err=1 for one cycle, pc_out <= pc_in.
REQ-023 All PC arithmetic modulo 2^WIDTH; wrap-around silent, no flag.
REQ-024 Stack LIFO; count range 0..RAS_DEPTH; ras_empty/ras_full registered-state-derived, valid same cycle as count.
REQ-025 pc_out+STEP computed from pre-edge pc_out for both INC and CALL push value.

Reset
REQ-026 rst=1 at rising edge: pc_out <= RESET_VEC, stack count <= 0, ras_empty=1, ras_full=0, ras_err=0.
REQ-027 rst has priority over pc_ld and pc_mode, including mid CALL/RET; stack entry contents need not be cleared.

Configuration
REQ-028 Macro PC_RAS_EN defined: stack, ras_* outputs and CALL/RET behave per REQ-019..022.
REQ-029 PC_RAS_EN undefined: no stack storage; CALL acts as JMP, RET as INC; ras_empty tied 1, ras_full 0, ras_err 0.

Structure
REQ-030 Shared package pc_pkg holds pc_mode encodings (PC_INC, PC_BR, PC_JMP, PC_CALL, PC_RET) and the mode-width constant.
REQ-031 Stack implemented as sub-module pc_ras (push, pop, top, count, full, empty), instantiated only under PC_RAS_EN.

Verification
REQ-032 Reset: rst=1 one cycle, RESET_VEC=0 -> pc_out=0, ras_empty=1; then INC x3 with pc_ld=1 -> pc_out 1,2,3.
REQ-033 Stall/branch: pc_out=10, pc_ld=0 two cycles -> pc_out=10; BR pc_off=-4 -> 6; JMP pc_in=100 -> 100.
REQ-034 Call/return: pc_out=5, CALL pc_in=40 -> 40, ras_empty=0; INC -> 41; RET -> 6, ras_empty=1.
REQ-035 Overflow/underflow: RAS_DEPTH=4, five CALLs -> ras_full=1, ras_err pulse on fifth; four RETs return last four push values; fifth RET -> ras_err pulse, pc_out+1.
REQ-036 Wrap and reset priority: WIDTH=8, pc_out=255, INC -> 0; rst=1 coincident with CALL -> pc_out=RESET_VEC, ras_empty=1.
REQ-037 Build without PC_RAS_EN: CALL pc_in=20 -> pc_out=20; RET -> 21; ras_err never asserted.
